// File: rtl/axi_wr_arbiter.sv
// axi_wr_arbiter: round-robin arbiter sharing one AXI write port (AW/W/B) between NUM_REQ requesters
// Ports: clk, rst (sync, active-high); i_s_* per-requester AW/W payload and handshakes (requester i at slice i);
// o_s_awready/o_s_wready/o_s_bvalid/o_s_bresp back to requesters; o_m_* downstream AW/W/B outputs;
// i_m_* downstream readies and B response; o_grant one-hot grant; o_err_beat sticky W beat-count error.
// Optional: define AXI_ARB_BEAT_CHECK_EN to enable the W beat counter behind o_err_beat (tied 0 otherwise).
module axi_wr_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    i_s_awaddr,
    input  logic [NUM_REQ*ID_WIDTH-1:0]      i_s_awid,
    input  logic [NUM_REQ*8-1:0]             i_s_awlen,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    i_s_wdata,
    input  logic [NUM_REQ*DATA_WIDTH/8-1:0]  i_s_wstrb,
    input  logic [NUM_REQ-1:0]               i_s_wlast,
    input  logic [NUM_REQ-1:0]               i_s_awvalid,
    input  logic [NUM_REQ-1:0]               i_s_wvalid,
    input  logic [NUM_REQ-1:0]               i_s_bready,
    output logic [NUM_REQ-1:0]               o_s_awready,
    output logic [NUM_REQ-1:0]               o_s_wready,
    output logic [NUM_REQ-1:0]               o_s_bvalid,
    output logic [NUM_REQ*2-1:0]             o_s_bresp,
    output logic [ADDR_WIDTH-1:0]            o_m_awaddr,
    output logic [ID_WIDTH-1:0]              o_m_awid,
    output logic [7:0]                       o_m_awlen,
    output logic [DATA_WIDTH-1:0]            o_m_wdata,
    output logic [DATA_WIDTH/8-1:0]          o_m_wstrb,
    output logic                             o_m_wlast,
    output logic                             o_m_awvalid,
    output logic                             o_m_wvalid,
    output logic                             o_m_bready,
    input  logic                             i_m_awready,
    input  logic                             i_m_wready,
    input  logic                             i_m_bvalid,
    input  logic [1:0]                       i_m_bresp,
    output logic [NUM_REQ-1:0]               o_grant,
    output logic                             o_err_beat
);
    localparam int GW = $clog2(NUM_REQ);
    localparam int SW = DATA_WIDTH / 8;
    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;
    state_t             r_state, w_next;
    logic [GW-1:0]      r_g, r_ptr, w_pick;
    logic [NUM_REQ-1:0] r_grant;
    logic               w_found, w_aw_hs, w_w_hs, w_b_hs;
    // Payload muxes follow the registered grant index only; no data-path registers.
    assign o_m_awaddr  = i_s_awaddr[r_g*ADDR_WIDTH +: ADDR_WIDTH];
    assign o_m_awid    = i_s_awid[r_g*ID_WIDTH +: ID_WIDTH];
    assign o_m_awlen   = i_s_awlen[r_g*8 +: 8];
    assign o_m_wdata   = i_s_wdata[r_g*DATA_WIDTH +: DATA_WIDTH];
    assign o_m_wstrb   = i_s_wstrb[r_g*SW +: SW];
    assign o_m_wlast   = i_s_wlast[r_g];
    assign o_m_awvalid = (r_state == ADDR) && i_s_awvalid[r_g];
    assign o_m_wvalid  = (r_state == DATA) && i_s_wvalid[r_g];
    assign o_m_bready  = (r_state == RESP) && i_s_bready[r_g];
    // Masking with the one-hot grant keeps every non-granted requester's ready/bvalid low.
    assign o_s_awready = {NUM_REQ{(r_state == ADDR) && i_m_awready}} & r_grant;
    assign o_s_wready  = {NUM_REQ{(r_state == DATA) && i_m_wready}} & r_grant;
    assign o_s_bvalid  = {NUM_REQ{(r_state == RESP) && i_m_bvalid}} & r_grant;
    assign o_s_bresp   = {NUM_REQ{i_m_bresp}};
    assign o_grant     = r_grant;
    assign w_aw_hs     = o_m_awvalid && i_m_awready;
    assign w_w_hs      = o_m_wvalid && i_m_wready;
    assign w_b_hs      = o_m_bready && i_m_bvalid;
    // First requesting index scanning upward from r_ptr with wrap.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_found && i_s_awvalid[(int'(r_ptr) + k) % NUM_REQ]) begin
                w_found = 1'b1;
                w_pick  = GW'((int'(r_ptr) + k) % NUM_REQ);
            end
        end
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_found ? ADDR : IDLE;
            ADDR:    w_next = w_aw_hs ? DATA : ADDR;
            DATA:    w_next = (w_w_hs && o_m_wlast) ? RESP : DATA;
            default: w_next = w_b_hs ? IDLE : RESP;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_g     <= '0;
            r_ptr   <= '0;
            r_grant <= '0;
        end else if (r_state == IDLE && w_found) begin
            r_g     <= w_pick;
            r_grant <= NUM_REQ'(1) << w_pick;
        end else if (w_b_hs) begin
            r_grant <= '0;
            r_ptr   <= (r_g == GW'(NUM_REQ - 1)) ? '0 : r_g + 1'b1;
        end
    end
`ifdef AXI_ARB_BEAT_CHECK_EN
    logic [7:0] r_cnt, r_len;
    logic       r_err;
    // r_cnt is the index of the beat being handshaked; wlast must coincide exactly with index awlen.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_len <= '0;
            r_err <= 1'b0;
        end else if (w_aw_hs) begin
            r_cnt <= '0;
            r_len <= o_m_awlen;
        end else if (w_w_hs) begin
            r_cnt <= r_cnt + 8'd1;
            if (o_m_wlast != (r_cnt == r_len)) r_err <= 1'b1;
        end
    end
    assign o_err_beat = r_err;
`else
    assign o_err_beat = 1'b0;
`endif
endmodule

// File: tb/tb_axi_wr_arbiter.sv
// tb_axi_wr_arbiter: randomized self-checking bench for axi_wr_arbiter against a round-robin transaction model
module tb_axi_wr_arbiter;
    localparam int N = 2, AW = 32, DW = 64, IW = 4, SW = DW / 8;
    logic clk = 1'b0, rst = 1'b1;
    logic [N*AW-1:0] s_awaddr = '0;
    logic [N*IW-1:0] s_awid = '0;
    logic [N*8-1:0] s_awlen = '0;
    logic [N*DW-1:0] s_wdata = '0;
    logic [N*SW-1:0] s_wstrb = '0;
    logic [N-1:0] s_wlast = '0, s_awvalid = '0, s_wvalid = '0, s_bready = '0;
    logic [N-1:0] s_awready, s_wready, s_bvalid, grant;
    logic [N*2-1:0] s_bresp;
    logic [AW-1:0] m_awaddr;
    logic [IW-1:0] m_awid;
    logic [7:0] m_awlen;
    logic [DW-1:0] m_wdata;
    logic [SW-1:0] m_wstrb;
    logic m_wlast, m_awvalid, m_wvalid, m_bready, err_beat;
    logic m_awready = 1'b1, m_wready = 1'b1, m_bvalid = 1'b0;
    logic [1:0] m_bresp = 2'b00;
    int n_chk = 0, n_fail = 0, mdl_ptr = 0;
    bit ph = 1'b1;
    logic [AW-1:0] e_addr [N];
    logic [IW-1:0] e_id [N];
    logic [7:0] e_len [N];
`ifdef AXI_ARB_BEAT_CHECK_EN
    localparam bit ERR_ON = 1'b1;
`else
    localparam bit ERR_ON = 1'b0;
`endif
    always #5 clk = ~clk;
    axi_wr_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
        .clk(clk), .rst(rst),
        .i_s_awaddr(s_awaddr), .i_s_awid(s_awid), .i_s_awlen(s_awlen),
        .i_s_wdata(s_wdata), .i_s_wstrb(s_wstrb), .i_s_wlast(s_wlast),
        .i_s_awvalid(s_awvalid), .i_s_wvalid(s_wvalid), .i_s_bready(s_bready),
        .o_s_awready(s_awready), .o_s_wready(s_wready), .o_s_bvalid(s_bvalid), .o_s_bresp(s_bresp),
        .o_m_awaddr(m_awaddr), .o_m_awid(m_awid), .o_m_awlen(m_awlen),
        .o_m_wdata(m_wdata), .o_m_wstrb(m_wstrb), .o_m_wlast(m_wlast),
        .o_m_awvalid(m_awvalid), .o_m_wvalid(m_wvalid), .o_m_bready(m_bready),
        .i_m_awready(m_awready), .i_m_wready(m_wready), .i_m_bvalid(m_bvalid), .i_m_bresp(m_bresp),
        .o_grant(grant), .o_err_beat(err_beat)
    );
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    function automatic int pick(input logic [N-1:0] v);
        for (int k = 0; k < N; k++) if (v[(mdl_ptr + k) % N]) return (mdl_ptr + k) % N;
        return 0;
    endfunction
    task automatic post(input int r, input logic [7:0] len);
        e_addr[r] = $urandom;
        e_id[r] = IW'($urandom);
        e_len[r] = len;
        s_awaddr[r*AW +: AW] = e_addr[r];
        s_awid[r*IW +: IW] = e_id[r];
        s_awlen[r*8 +: 8] = len;
        s_awvalid[r] = 1'b1;
    endtask
    task automatic serve(input int nbeats, input bit tog, output int g);
        logic [N-1:0] oh;
        logic [DW-1:0] d;
        logic [SW-1:0] st;
        logic [1:0] br;
        bit acc;
        int cyc;
        g = pick(s_awvalid);
        oh = '0;
        oh[g] = 1'b1;
        cyc = 0;
        while (grant === '0 && cyc < 20) begin
            tick();
            cyc++;
        end
        n_chk++; if (grant !== oh || cyc !== 1) begin n_fail++; $display("FAIL grant: got %b after %0d cycles, want %b after 1", grant, cyc, oh); end
        m_awready = 1'b0;
        m_wready = 1'b1;
        s_wvalid[g] = 1'b1;
        #1;
        n_chk++; if ({m_awvalid, m_awaddr, m_awid, m_awlen} !== {1'b1, e_addr[g], e_id[g], e_len[g]}) begin n_fail++; $display("FAIL aw_payload: got v=%b %h %h %h want 1 %h %h %h", m_awvalid, m_awaddr, m_awid, m_awlen, e_addr[g], e_id[g], e_len[g]); end
        n_chk++; if ({s_awready, s_wready, m_wvalid} !== '0) begin n_fail++; $display("FAIL early_w_stall: got awready=%b wready=%b m_wvalid=%b want all 0", s_awready, s_wready, m_wvalid); end
        tick();
        m_awready = 1'b1;
        #1;
        n_chk++; if (s_awready !== oh) begin n_fail++; $display("FAIL s_awready: got %b want %b", s_awready, oh); end
        tick();
        s_awvalid[g] = 1'b0;
        for (int b = 0; b < nbeats; b++) begin
            d = {$urandom, $urandom};
            st = SW'($urandom);
            s_wdata[g*DW +: DW] = d;
            s_wstrb[g*SW +: SW] = st;
            s_wlast[g] = (b == nbeats - 1);
            cyc = 0;
            acc = 1'b0;
            while (!acc && cyc < 20) begin
                m_wready = tog ? ph : 1'b1;
                ph = ~ph;
                #1;
                n_chk++; if ({m_wvalid, m_wdata, m_wstrb, m_wlast} !== {1'b1, d, st, b == nbeats - 1}) begin n_fail++; $display("FAIL w_beat%0d: got v=%b %h %h %b want 1 %h %h %b", b, m_wvalid, m_wdata, m_wstrb, m_wlast, d, st, b == nbeats - 1); end
                n_chk++; if (s_wready !== (m_wready ? oh : '0)) begin n_fail++; $display("FAIL s_wready%0d: got %b want %b", b, s_wready, m_wready ? oh : '0); end
                acc = m_wready;
                tick();
                cyc++;
            end
        end
        s_wvalid[g] = 1'b0;
        s_wlast[g] = 1'b0;
        br = 2'($urandom);
        m_bresp = br;
        m_bvalid = 1'b1;
        s_bready[g] = 1'b1;
        #1;
        n_chk++; if ({s_bvalid, m_bready, s_bresp} !== {oh, 1'b1, {N{br}}}) begin n_fail++; $display("FAIL b_resp: got bvalid=%b bready=%b bresp=%b want %b 1 %b", s_bvalid, m_bready, s_bresp, oh, {N{br}}); end
        tick();
        m_bvalid = 1'b0;
        s_bready = '0;
        #1;
        n_chk++; if ({grant, m_awvalid, m_wvalid, m_bready, s_bvalid} !== '0) begin n_fail++; $display("FAIL idle_after_b: got grant=%b awv=%b wv=%b br=%b bv=%b want 0", grant, m_awvalid, m_wvalid, m_bready, s_bvalid); end
        mdl_ptr = (g + 1) % N;
    endtask
    task automatic test_reset();
        rst = 1'b1;
        s_awaddr = {$urandom, $urandom};
        tick();
        tick();
        rst = 1'b0;
        mdl_ptr = 0;
        #1;
        n_chk++; if ({grant, err_beat, m_awvalid, m_wvalid, m_bready, s_awready, s_wready, s_bvalid} !== '0) begin n_fail++; $display("FAIL reset_state: got grant=%b err=%b awv=%b wv=%b br=%b sawr=%b swr=%b sbv=%b want 0", grant, err_beat, m_awvalid, m_wvalid, m_bready, s_awready, s_wready, s_bvalid); end
        n_chk++; if (m_awaddr !== s_awaddr[AW-1:0]) begin n_fail++; $display("FAIL reset_mux: got %h want %h", m_awaddr, s_awaddr[AW-1:0]); end
    endtask
    task automatic test_contention();
        int g;
        post(0, 8'd2);
        post(1, 8'd1);
        serve(3, 1'b0, g);
        n_chk++; if (g !== 0 || s_awvalid[1] !== 1'b1 || grant !== '0) begin n_fail++; $display("FAIL contention_first: got g=%0d grant=%b want g=0 grant=00 in gap", g, grant); end
        serve(2, 1'b0, g);
        n_chk++; if (g !== 1) begin n_fail++; $display("FAIL contention_second: got %0d want 1", g); end
    endtask
    task automatic test_single();
        int g;
        post(0, 8'd3);
        e_addr[0] = 32'h1000;
        s_awaddr[AW-1:0] = 32'h1000;
        serve(4, 1'b0, g);
        n_chk++; if (mdl_ptr !== 1 || g !== 0) begin n_fail++; $display("FAIL single: got g=%0d ptr=%0d want 0 1", g, mdl_ptr); end
    endtask
    task automatic test_rotation();
        int g;
        test_reset();
        post(0, 8'($urandom_range(0, 3)));
        post(1, 8'($urandom_range(0, 3)));
        for (int i = 0; i < 6; i++) begin
            serve(int'(e_len[pick(s_awvalid)]) + 1, 1'b0, g);
            n_chk++; if (g !== i % 2) begin n_fail++; $display("FAIL rotation%0d: got %0d want %0d", i, g, i % 2); end
            post(g, 8'($urandom_range(0, 3)));
        end
        s_awvalid = '0;
        tick();
    endtask
    task automatic test_toggle();
        int g;
        ph = 1'b1;
        post(0, 8'd7);
        serve(8, 1'b1, g);
    endtask
    task automatic test_mid_reset();
        int g;
        post(1, 8'd3);
        tick();
        n_chk++; if (grant !== 2'b10) begin n_fail++; $display("FAIL midrst_grant: got %b want 10", grant); end
        m_awready = 1'b1;
        m_wready = 1'b1;
        tick();
        s_awvalid = '0;
        s_wvalid[1] = 1'b1;
        s_wlast[1] = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mdl_ptr = 0;
        #1;
        n_chk++; if ({grant, m_awvalid, m_wvalid, m_bready, s_awready, s_wready, s_bvalid} !== '0) begin n_fail++; $display("FAIL midrst_idle: got grant=%b awv=%b wv=%b br=%b sawr=%b swr=%b sbv=%b want 0", grant, m_awvalid, m_wvalid, m_bready, s_awready, s_wready, s_bvalid); end
        s_wvalid = '0;
        post(0, 8'd1);
        post(1, 8'd0);
        serve(2, 1'b0, g);
        n_chk++; if (g !== 0) begin n_fail++; $display("FAIL midrst_ptr: got %0d want 0", g); end
        serve(1, 1'b0, g);
    endtask
    task automatic test_beat_err();
        int g;
        n_chk++; if (err_beat !== 1'b0) begin n_fail++; $display("FAIL err_clean: got %b want 0", err_beat); end
        post(0, 8'd3);
        serve(3, 1'b0, g);
        n_chk++; if (err_beat !== ERR_ON) begin n_fail++; $display("FAIL err_short: got %b want %b", err_beat, ERR_ON); end
        post(1, 8'd0);
        serve(1, 1'b0, g);
        n_chk++; if (err_beat !== ERR_ON) begin n_fail++; $display("FAIL err_sticky: got %b want %b", err_beat, ERR_ON); end
        test_reset();
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        test_reset();
        test_contention();
        test_single();
        test_rotation();
        test_toggle();
        test_mid_reset();
        post(1, 8'd0);
        begin
            int g;
            serve(1, 1'b0, g);
        end
        test_beat_err();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/axi_wr_arbiter.md
Name: axi_wr_arbiter

Overview:
- Shares one downstream AXI write port (AW/W/B) between NUM_REQ upstream write requesters, e.g. cache write-back and the merged external write path.
- Grants one requester at a time, round-robin.
- The grant is held from AW acceptance through the final W beat to the B handshake, so at most one write transaction is outstanding downstream.
- Downstream assumes INCR bursts at full DATA_WIDTH; no burst or size fields are carried.

Parameters:
NUM_REQ, 2, number of upstream requesters (>=2)
ADDR_WIDTH, 32, AW address width
DATA_WIDTH, 64, W data width; strobe width is DATA_WIDTH/8
ID_WIDTH, 4, AW ID width; ID passes through unmodified

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
s_awaddr, s_awid, s_awlen  in  NUM_REQ*ADDR_WIDTH / NUM_REQ*ID_WIDTH / NUM_REQ*8  per-requester AW payload, flattened, requester i at slice i
s_wdata, s_wstrb, s_wlast  in  NUM_REQ*DATA_WIDTH / NUM_REQ*DATA_WIDTH/8 / NUM_REQ  per-requester W payload
s_awvalid, s_wvalid, s_bready  in  NUM_REQ each  per-requester handshake inputs
s_awready, s_wready, s_bvalid  out  NUM_REQ each  per-requester handshake outputs
s_bresp  out  NUM_REQ*2  m_bresp replicated to every slice; qualified by s_bvalid
m_awaddr, m_awid, m_awlen  out  ADDR_WIDTH / ID_WIDTH / 8  downstream AW payload
m_wdata, m_wstrb, m_wlast  out  DATA_WIDTH / DATA_WIDTH/8 / 1  downstream W payload
m_awvalid, m_wvalid, m_bready  out  1 each  downstream handshake outputs
m_awready, m_wready, m_bvalid  in  1 each  downstream handshake inputs
m_bresp  in  2  downstream write response
grant  out  NUM_REQ  one-hot registered grant; all zero in IDLE
err_beat  out  1  sticky W beat-count error (see Optional Feature)

Behaviour:
- State machine: IDLE, ADDR, DATA, RESP.
- Registers: state, grant index g, rr_ptr (priority start index), busy-one-hot grant.
- Reset (rst=1 at posedge): state=IDLE, grant=0, rr_ptr=0, err_beat=0.
  - All s_*ready, s_bvalid, m_*valid, m_bready read 0 while in IDLE.
  - Payload outputs carry the mux of requester 0 (don't-care).
- Reset mid-transaction: abandons the burst immediately; the next cycle is IDLE with all valids 0; no completion is signalled.
- IDLE:
  - If any s_awvalid is set, select the first set bit scanning from rr_ptr upward with wrap.
  - Register g and grant, then go to ADDR.
  - No handshake occurs in IDLE, so there is a 1-cycle arbitration bubble: s_awvalid at cycle t gives m_awvalid at t+1.
- ADDR:
  - m_aw* = s_aw*[g]; m_awvalid = s_awvalid[g]; s_awready[g] = m_awready; other s_awready = 0.
  - On m_awvalid & m_awready go to DATA.
  - A requester dropping awvalid before the handshake is a protocol violation and is unsupported.
- DATA:
  - m_w* = s_w*[g]; m_wvalid = s_wvalid[g]; s_wready[g] = m_wready; others 0.
  - W presented before DATA is stalled: s_wready stays 0.
  - On handshake with m_wlast=1 go to RESP.
- RESP:
  - m_bready = s_bready[g]; s_bvalid[g] = m_bvalid; others 0.
  - On B handshake: IDLE, grant=0, rr_ptr = (g+1) mod NUM_REQ.
- Back-to-back grants: minimum 1 IDLE cycle between transactions.
- Simultaneous requests: strict rotation; a requester waits at most NUM_REQ-1 transactions.
- awlen=0: single beat; wlast is expected on the first beat.
- All muxes are combinational from registered g and state; no data-path registers.
- Only the granted requester ever sees ready/bvalid asserted.

Optional Feature:
AXI_ARB_BEAT_CHECK_EN
- Defined:
  - An 8-bit beat counter loads 0 on AW handshake and increments on each W handshake.
  - err_beat is set (sticky until rst) when wlast is handshaked with counter != latched awlen, or when the counter reaches awlen without wlast.
  - DATA still exits only on wlast.
- Undefined: no counter; err_beat is tied 0.

Test Plan:
- Single requester 0, awaddr=0x1000, awlen=3, m_* always ready, B=OKAY
  -> grant=01 one cycle after s_awvalid; 4 W beats pass in order; s_bvalid[0]=1, s_bvalid[1]=0; back to IDLE; rr_ptr=1.
- Both requesters assert awvalid in the same cycle after reset
  -> requester 0 served first (grant 01), then requester 1 (grant 10); the 1-cycle IDLE gap between them is observed.
- Both requesters request continuously for 6 transactions
  -> grant sequence 01,10,01,10,01,10; no starvation.
- m_wready toggles 1,0,1,0 during awlen=7 burst
  -> s_wready[g] mirrors m_wready; exactly 8 beats with identical data/strobe; wlast only on beat 8.
- rst pulsed in DATA after 2 of 4 beats
  -> next cycle grant=0, all valids/readies 0, rr_ptr=0; a new request is then served normally.
- With AXI_ARB_BEAT_CHECK_EN, awlen=3 and wlast on the 3rd beat
  -> err_beat=1 from the following cycle and stays 1 until rst; without the macro err_beat stays 0.
